in_dev_ctrl: RTL and testbench
==============================

# in_dev_ctrl

Input-device controller feeding the microprogrammed CPU's `IN` byte and `interrupt` line. It synchronises and debounces a request pushbutton and captures the 8-bit data switches on each debounced press. It then holds the byte for the CPU and raises an interrupt request, which it keeps pending until the CPU acknowledges and reads the byte. It sits directly upstream of the CPU: `in_data` drives the CPU's input-device register path and `interrupt` drives its interrupt input.

## Interface
Parameters:
- `DB_CYCLES`, 16: consecutive stable cycles needed before the debounced key level changes. Legal range 2..255.
- `W`, 8: data width of the switches and `in_data`.

Ports:
- `clk` in 1: single system clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-low. Sampled on the `clk` rising edge; `reset`=0 resets the block.
- `sw` in W: raw data switches, asynchronous.
- `key` in 1: raw request pushbutton, asynchronous, active-high, bouncy.
- `int_en` in 1: CPU interrupt-enable state (1 after STI, 0 after CLI).
- `int_ack` in 1: one-cycle pulse from the CPU when it takes the interrupt branch.
- `rd` in 1: one-cycle pulse when the CPU loads `in_data` onto its bus.
- `in_data` out W: held captured byte.
- `data_valid` out 1: `in_data` holds an unread byte.
- `interrupt` out 1: request to the CPU.
- `overrun` out 1: sticky flag; a press was lost because the previous byte was unread.

## Operation
- Synchroniser: `key` and `sw` each pass through 2 flops, giving `key_s` and `sw_s`.
- Debouncer:
  - Counter `db_cnt`, 8 bits. It increments while `key_s` differs from `key_db` and clears to 0 when they are equal.
  - When `db_cnt` reaches DB_CYCLES-1 while the two still differ, `key_db` toggles and `db_cnt` clears.
  - A rising edge of `key_db` produces a one-cycle internal `press` strobe.
- State machine, 2-bit `state`:
  - IDLE: no unread byte. On `press`, capture `sw_s` into `in_data`, set `data_valid`=1 and `pending`=1, and go to PEND.
  - PEND: request outstanding.
    - `int_ack` clears `pending` and moves to SERV.
    - `rd` without `int_ack` (polled read) clears `data_valid` and `pending` and moves to IDLE.
  - SERV: acknowledged, waiting for the read. `rd` clears `data_valid` and moves to IDLE.
- `interrupt` = `pending` AND `int_en`, combinational from registered `pending`. With `int_en`=0, `pending` is held and `interrupt` rises as soon as `int_en` returns to 1.
- `press` in PEND or SERV without `rd` in the same cycle:
  - `in_data` is not overwritten.
  - `overrun` is set.
- `press` and `rd` in the same cycle, any non-IDLE state:
  - The old byte counts as consumed.
  - The new `sw_s` is captured, `data_valid` stays 1, `pending` is set, and the state goes to PEND.
  - `overrun` is not set.
- `int_ack` in IDLE or SERV is ignored. `rd` in IDLE is ignored; `in_data` is unchanged.
- `overrun` clears on the first `rd` after it is set, unless a lost press occurs in that same cycle.
- Reset (`reset`=0), including mid-debounce or mid-service:
  - `state`=IDLE; `in_data`=0, `data_valid`=0, `pending`=0, `interrupt`=0, `overrun`=0.
  - `key_db`=0, `db_cnt`=0; synchroniser flops cleared to 0.

## Timing
- `key` rising at edge 0 and held stable:
  - `key_s`=1 after edge 2.
  - `key_db`=1 after edge 2+DB_CYCLES.
  - `data_valid`, `pending` and `in_data` update at edge 3+DB_CYCLES.
  - `interrupt` is high in the same cycle if `int_en`=1.
- `sw` must be stable for 2 cycles before the capture edge; the captured value is `sw_s` at that edge.
- A bounce shorter than DB_CYCLES cycles never changes `key_db`.
- A key release needs the same DB_CYCLES filtering before another press can be detected.
- `int_ack` and `rd` take effect at the edge on which they are sampled high:
  - `interrupt` drops in the cycle after `int_ack`.
  - `data_valid` drops in the cycle after `rd`.
- Only one `press` is possible per DB_CYCLES+1 cycles, so there is no multi-press queueing.

## Test plan
- Reset: hold `reset`=0 for 3 cycles while `key`=1 and `sw`=8'hFF -> all outputs 0. After release, `interrupt` rises exactly at edge 3+DB_CYCLES counted from the first cycle with `reset`=1.
- Bounce rejection, DB_CYCLES=16: toggle `key` with 5-cycle pulses for 60 cycles -> `data_valid` stays 0. Then hold `key`=1 -> capture 19 cycles after the hold starts.
- Interrupt flow: `sw`=8'h44, press, `int_en`=1 -> `interrupt`=1 and `in_data`=8'h44. Pulse `int_ack` -> `interrupt`=0 and `data_valid`=1. Pulse `rd` -> `data_valid`=0 and state IDLE.
- Masking: `int_en`=0, press with `sw`=8'h12 -> `interrupt`=0 and `data_valid`=1. Set `int_en`=1 -> `interrupt`=1 in the same cycle.
- Overrun: press `sw`=8'hA5, release, press `sw`=8'h3C with no read -> `in_data`=8'hA5 and `overrun`=1. `rd` -> `overrun`=0 and `data_valid`=0.
- Simultaneous: `rd` on the same edge as `press` with `sw`=8'h77 -> `in_data`=8'h77, `data_valid`=1, `overrun`=0, state PEND.

Source files
------------

// File: rtl/in_dev_ctrl.sv
// Input-device controller: synchronises and debounces the request key, captures
// the data switches on each debounced press, and holds the byte with an
// interrupt request until the CPU acknowledges and reads it.
module in_dev_ctrl #(
    parameter int DB_CYCLES = 16,
    parameter int W         = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] sw,
    input  logic         key,
    input  logic         int_en,
    input  logic         int_ack,
    input  logic         rd,
    output logic [W-1:0] in_data,
    output logic         data_valid,
    output logic         interrupt,
    output logic         overrun
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        SERV = 2'd2
    } state_t;

    localparam logic [7:0] DB_LAST = 8'(DB_CYCLES - 1);

    logic         key_p0;
    logic         key_s;
    logic [W-1:0] sw_p0;
    logic [W-1:0] sw_s;

    logic [7:0]   db_cnt;
    logic         key_db;
    logic         key_db_d;
    logic         press;

    state_t       state;
    state_t       state_nxt;
    logic [W-1:0] in_data_nxt;
    logic         data_valid_nxt;
    logic         pending;
    logic         pending_nxt;
    logic         overrun_nxt;
    logic         lost_press;

    // Two-flop synchronisers for the asynchronous key and switch inputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            key_p0 <= 1'b0;
            key_s  <= 1'b0;
            sw_p0  <= '0;
            sw_s   <= '0;
        end else begin
            key_p0 <= key;
            key_s  <= key_p0;
            sw_p0  <= sw;
            sw_s   <= sw_p0;
        end
    end

    // Debounce: the filtered level follows key_s only after DB_CYCLES stable cycles
    always_ff @(posedge clk) begin
        if (!reset) begin
            db_cnt   <= 8'd0;
            key_db   <= 1'b0;
            key_db_d <= 1'b0;
        end else begin
            key_db_d <= key_db;
            if (key_s == key_db) begin
                db_cnt <= 8'd0;
            end else if (db_cnt == DB_LAST) begin
                key_db <= ~key_db;
                db_cnt <= 8'd0;
            end else begin
                db_cnt <= db_cnt + 8'd1;
            end
        end
    end

    // One-cycle strobe on each debounced rising edge
    assign press = key_db & ~key_db_d;

    // A press that arrives while an unread byte is held and is not consumed this cycle
    assign lost_press = press && !rd && (state != IDLE);

    // State and data registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            in_data    <= '0;
            data_valid <= 1'b0;
            pending    <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state      <= state_nxt;
            in_data    <= in_data_nxt;
            data_valid <= data_valid_nxt;
            pending    <= pending_nxt;
            overrun    <= overrun_nxt;
        end
    end

    // Next-state and next-data decode
    always_comb begin
        state_nxt      = state;
        in_data_nxt    = in_data;
        data_valid_nxt = data_valid;
        pending_nxt    = pending;
        overrun_nxt    = overrun;

        if (lost_press) begin
            overrun_nxt = 1'b1;
        end else if (rd) begin
            overrun_nxt = 1'b0;
        end

        case (state)
            IDLE: begin
                if (press) begin
                    in_data_nxt    = sw_s;
                    data_valid_nxt = 1'b1;
                    pending_nxt    = 1'b1;
                    state_nxt      = PEND;
                end
            end
            PEND: begin
                if (press && rd) begin
                    in_data_nxt    = sw_s;
                    data_valid_nxt = 1'b1;
                    pending_nxt    = 1'b1;
                    state_nxt      = PEND;
                end else if (int_ack) begin
                    pending_nxt = 1'b0;
                    state_nxt   = SERV;
                end else if (rd) begin
                    data_valid_nxt = 1'b0;
                    pending_nxt    = 1'b0;
                    state_nxt      = IDLE;
                end
            end
            SERV: begin
                if (press && rd) begin
                    in_data_nxt    = sw_s;
                    data_valid_nxt = 1'b1;
                    pending_nxt    = 1'b1;
                    state_nxt      = PEND;
                end else if (rd) begin
                    data_valid_nxt = 1'b0;
                    state_nxt      = IDLE;
                end
            end
            default: begin
                state_nxt      = IDLE;
                data_valid_nxt = 1'b0;
                pending_nxt    = 1'b0;
            end
        endcase
    end

    assign interrupt = pending & int_en;

endmodule

// File: tb/tb_in_dev_ctrl.sv
// Self-checking bench for in_dev_ctrl: directed sequences plus a table of
// press/acknowledge/read transactions with hand-computed expectations.
module tb_in_dev_ctrl;

    localparam int DB = 16;

    logic       clk;
    logic       reset;
    logic [7:0] sw;
    logic       key;
    logic       int_en;
    logic       int_ack;
    logic       rd;
    logic [7:0] in_data;
    logic       data_valid;
    logic       interrupt;
    logic       overrun;

    int checks   = 0;
    int failures = 0;

    in_dev_ctrl #(.DB_CYCLES(DB), .W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .sw         (sw),
        .key        (key),
        .int_en     (int_en),
        .int_ack    (int_ack),
        .rd         (rd),
        .in_data    (in_data),
        .data_valid (data_valid),
        .interrupt  (interrupt),
        .overrun    (overrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    typedef struct packed {
        logic [7:0] sw;
        logic       int_en;
        logic       exp_int;
    } vec_t;

    vec_t vecs [0:4];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic key_hold(input logic [7:0] v);
        sw  = v;
        key = 1'b1;
        repeat (DB + 3) tick();
    endtask

    task automatic key_release();
        key = 1'b0;
        repeat (DB + 3) tick();
    endtask

    task automatic pulse_rd();
        rd = 1'b1;
        tick();
        rd = 1'b0;
    endtask

    task automatic pulse_ack();
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
    endtask

    initial begin
        int bounce_hits;

        vecs[0] = '{sw: 8'h44, int_en: 1'b1, exp_int: 1'b1};
        vecs[1] = '{sw: 8'h12, int_en: 1'b0, exp_int: 1'b0};
        vecs[2] = '{sw: 8'h00, int_en: 1'b1, exp_int: 1'b1};
        vecs[3] = '{sw: 8'hFF, int_en: 1'b0, exp_int: 1'b0};
        vecs[4] = '{sw: 8'h81, int_en: 1'b1, exp_int: 1'b1};

        reset   = 1'b0;
        sw      = 8'hFF;
        key     = 1'b1;
        int_en  = 1'b1;
        int_ack = 1'b0;
        rd      = 1'b0;

        // Reset held with key and switches active
        repeat (3) tick();
        check("rst_in_data", 32'(in_data), 32'h00);
        check("rst_valid", 32'(data_valid), 32'h0);
        check("rst_interrupt", 32'(interrupt), 32'h0);
        check("rst_overrun", 32'(overrun), 32'h0);

        // Release: capture lands exactly DB+3 edges later
        reset = 1'b1;
        repeat (DB + 2) tick();
        check("rst_early_interrupt", 32'(interrupt), 32'h0);
        check("rst_early_valid", 32'(data_valid), 32'h0);
        tick();
        check("rst_capture_interrupt", 32'(interrupt), 32'h1);
        check("rst_capture_data", 32'(in_data), 32'hFF);
        key_release();
        pulse_rd();
        check("rst_rd_valid", 32'(data_valid), 32'h0);

        // Bounce rejection: 5-cycle pulses for 60 cycles, ending low
        bounce_hits = 0;
        sw = 8'h5A;
        for (int i = 0; i < 12; i++) begin
            key = (i % 2 == 0);
            for (int j = 0; j < 5; j++) begin
                tick();
                if (data_valid) bounce_hits++;
            end
        end
        check("bounce_no_capture", 32'(bounce_hits), 32'd0);
        key = 1'b1;
        repeat (DB + 2) tick();
        check("bounce_hold_early", 32'(data_valid), 32'h0);
        tick();
        check("bounce_hold_valid", 32'(data_valid), 32'h1);
        check("bounce_hold_data", 32'(in_data), 32'h5A);
        key_release();
        pulse_rd();
        check("bounce_rd_valid", 32'(data_valid), 32'h0);

        // Table: press, optional unmask, acknowledge, read
        for (int k = 0; k < 5; k++) begin
            int_en = vecs[k].int_en;
            key_hold(vecs[k].sw);
            check("vec_data", 32'(in_data), 32'(vecs[k].sw));
            check("vec_valid", 32'(data_valid), 32'h1);
            check("vec_interrupt", 32'(interrupt), 32'(vecs[k].exp_int));
            check("vec_overrun", 32'(overrun), 32'h0);
            key_release();
            check("vec_int_held", 32'(interrupt), 32'(vecs[k].exp_int));
            if (!vecs[k].int_en) begin
                int_en = 1'b1;
                #1;
                check("vec_unmask_int", 32'(interrupt), 32'h1);
            end
            pulse_ack();
            check("vec_ack_int", 32'(interrupt), 32'h0);
            check("vec_ack_valid", 32'(data_valid), 32'h1);
            pulse_ack();
            check("vec_serv_ack_ignored", 32'(data_valid), 32'h1);
            pulse_rd();
            check("vec_rd_valid", 32'(data_valid), 32'h0);
            pulse_rd();
            check("vec_idle_rd_data", 32'(in_data), 32'(vecs[k].sw));
            check("vec_idle_rd_valid", 32'(data_valid), 32'h0);
        end

        // Overrun: second press lost while the first byte is unread
        int_en = 1'b1;
        key_hold(8'hA5);
        key_release();
        key_hold(8'h3C);
        key_release();
        check("ovr_data", 32'(in_data), 32'hA5);
        check("ovr_flag", 32'(overrun), 32'h1);
        check("ovr_valid", 32'(data_valid), 32'h1);
        pulse_rd();
        check("ovr_rd_flag", 32'(overrun), 32'h0);
        check("ovr_rd_valid", 32'(data_valid), 32'h0);

        // Simultaneous press and read while a byte is pending
        key_hold(8'h11);
        key_release();
        sw  = 8'h77;
        key = 1'b1;
        repeat (DB + 2) tick();
        rd = 1'b1;
        tick();
        rd = 1'b0;
        check("sim_data", 32'(in_data), 32'h77);
        check("sim_valid", 32'(data_valid), 32'h1);
        check("sim_overrun", 32'(overrun), 32'h0);
        check("sim_pend_int", 32'(interrupt), 32'h1);
        key_release();
        pulse_ack();
        check("sim_ack_int", 32'(interrupt), 32'h0);
        pulse_rd();
        check("sim_rd_valid", 32'(data_valid), 32'h0);
        pulse_ack();
        check("idle_ack_ignored", 32'(interrupt), 32'h0);

        // Reset in the middle of a pending request
        key_hold(8'h99);
        check("mid_valid_before", 32'(data_valid), 32'h1);
        reset = 1'b0;
        key   = 1'b0;
        tick();
        check("mid_rst_data", 32'(in_data), 32'h00);
        check("mid_rst_valid", 32'(data_valid), 32'h0);
        check("mid_rst_int", 32'(interrupt), 32'h0);
        reset = 1'b1;
        repeat (DB + 4) tick();
        check("mid_rst_no_press", 32'(data_valid), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
